dunit_inst_loader: RTL

DUNIT_INST_LOADER -- requirements
Module: dunit_inst_loader

---
 rtl/dunit_inst_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dunit_inst_loader.sv
// ---------------------------------------------------------------------------
// dunit_inst_loader
//
// Purpose:
//   Assembles a program received one byte at a time from the UART receiver
//   into instruction words and writes them sequentially into the instruction
//   memory, starting at byte address 0. A load starts on a single-cycle
//   i_start pulse from the debug FSM. It ends when the HALT_INST marker word
//   has been written, or when the last word slot of the memory has been
//   written. The halt word itself is written.
//
//   Bytes arrive most-significant first, so a word is big-endian on the wire.
//   Each complete word produces exactly one single-cycle memory write. A
//   partial word is never written.
//
// Parameters:
//   NB_REG    - instruction word width
//   NB_WIDHT  - instruction-memory byte-address width
//   NB_BYTE   - received byte width
//   HALT_INST - end-of-program marker word
//
// Ports:
//   i_clk          in   sole clock, rising edge
//   i_reset        in   asynchronous active-high reset
//   i_start        in   single-cycle pulse that begins a program load
//   i_rx_done      in   single-cycle strobe, i_rx_data holds a valid byte
//   i_rx_data      in   [NB_BYTE-1:0] received byte
//   o_dunit_w_en   out  instruction-memory write enable (one cycle per word)
//   o_dunit_addr   out  [NB_WIDHT-1:0] byte address of the word being written
//   o_dunit_data   out  [NB_REG-1:0] assembled instruction word
//   o_busy         out  high while loading or writing
//   o_done         out  single-cycle pulse when a load completes
//   o_full         out  valid with o_done; load ended on memory exhaustion
//   o_word_count   out  [NB_WIDHT-2:0] words written in current/last load
// ---------------------------------------------------------------------------
module dunit_inst_loader #(
  parameter int                NB_REG    = 32,
  parameter int                NB_WIDHT  = 9,
  parameter int                NB_BYTE   = 8,
  parameter logic [NB_REG-1:0] HALT_INST = 32'hFFFFFFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_rx_done,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  output logic                  o_dunit_w_en,
  output logic [NB_WIDHT-1:0]   o_dunit_addr,
  output logic [NB_REG-1:0]     o_dunit_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_full,
  output logic [NB_WIDHT-2:0]   o_word_count
);

  // Number of received bytes that make up one instruction word, and the
  // width of the index that counts through them.
  localparam int BYTES_PER_WORD = NB_REG / NB_BYTE;
  localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  // The memory is byte addressed, so consecutive words are NB_REG/8 apart.
  // LAST_ADDR is the address of the final word slot; writing there ends
  // the load so the address never wraps back onto word 0.
  localparam logic [NB_WIDHT-1:0] ADDR_STEP = NB_WIDHT'(NB_REG / 8);
  localparam logic [NB_WIDHT-1:0] LAST_ADDR = NB_WIDHT'((1 << NB_WIDHT) - (NB_REG / 8));
  localparam logic [BIDX_W-1:0]   LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [BIDX_W-1:0]   byte_idx;
  logic [NB_WIDHT-1:0] addr;
  logic [NB_REG-1:0]   asm_word;

  // Incoming byte appended at the low end; after BYTES_PER_WORD shifts the
  // first byte of the word has reached the most-significant position.
  logic [NB_REG-1:0] shifted_word;
  assign shifted_word = {asm_word[NB_REG-NB_BYTE-1:0], i_rx_data};

  // Loader FSM with all outputs registered. Strobes arriving in IDLE,
  // WRITE or DONE are dropped, as are i_start pulses outside IDLE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      byte_idx     <= '0;
      addr         <= '0;
      asm_word     <= '0;
      o_dunit_w_en <= 1'b0;
      o_dunit_addr <= '0;
      o_dunit_data <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_full       <= 1'b0;
      o_word_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state        <= LOAD;
            byte_idx     <= '0;
            addr         <= '0;
            asm_word     <= '0;
            o_word_count <= '0;
            o_full       <= 1'b0;
            o_busy       <= 1'b1;
          end
        end

        LOAD: begin
          if (i_rx_done) begin
            asm_word <= shifted_word;
            if (byte_idx == LAST_BYTE) begin
              // Word complete: present it to memory in the very next cycle.
              byte_idx     <= '0;
              state        <= WRITE;
              o_dunit_w_en <= 1'b1;
              o_dunit_data <= shifted_word;
              o_dunit_addr <= addr;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end

        WRITE: begin
          o_dunit_w_en <= 1'b0;
          o_word_count <= o_word_count + 1'b1;
          if (o_dunit_data == HALT_INST) begin
            state  <= DONE;
            addr   <= addr + ADDR_STEP;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (addr == LAST_ADDR) begin
            // Memory exhausted; hold the address at the last slot rather
            // than letting it wrap to 0.
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_full <= 1'b1;
          end else begin
            state <= LOAD;
            addr  <= addr + ADDR_STEP;
          end
        end

        DONE: begin
          // o_full and o_word_count are left untouched so the debug FSM can
          // read them until the next load starts.
          o_done <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state        <= IDLE;
          o_dunit_w_en <= 1'b0;
          o_busy       <= 1'b0;
          o_done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
